// File: rtl/aes_key_schedule.sv
// Iterative AES-128 key expansion: latches the cipher key and produces round keys
// 0..NR on request, one 32-bit word per cycle through a single shared SubWord.
module aes_key_schedule #(
    parameter int word_size  = 8,
    parameter int array_size = 16,
    parameter int NR         = 10
) (
    input  logic                                clk,
    input  logic                                rst,
    input  logic [word_size*array_size-1:0]     key_in,
    input  logic                                start,
    input  logic                                next,
    output logic [word_size*array_size-1:0]     round_key,
    output logic [3:0]                          round_num,
    output logic                                key_valid,
    output logic                                busy,
    output logic                                done
);

    localparam int KW = word_size * array_size;
    localparam logic [3:0] LAST_ROUND = 4'(NR);

    // FIPS-197 S-box; entry i sits at bits [8*(255-i) +: 8].
    localparam logic [2047:0] SBOX = {
        128'h637c777bf26b6fc53001672bfed7ab76,
        128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115,
        128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84,
        128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8,
        128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973,
        128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479,
        128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
        128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df,
        128'h8ca1890dbfe6426841992d0fb054bb16
    };

    typedef enum logic [1:0] {IDLE, READY, EXPAND} state_t;

    state_t     state;
    logic [7:0] rcon;
    logic [1:0] cnt;

    function automatic logic [7:0] sbox(input logic [7:0] b);
        logic [10:0] base;
        base = {~b, 3'b000};
        return SBOX[base +: 8];
    endfunction

    function automatic logic [7:0] xtime(input logic [7:0] v);
        return {v[6:0], 1'b0} ^ (v[7] ? 8'h1b : 8'h00);
    endfunction

    logic [31:0] w0, w1, w2, w3;
    logic [31:0] rot_w3, sub_w3, prev_word, new_word;
    logic [KW-1:0] next_key;

    assign w0 = round_key[127:96];
    assign w1 = round_key[95:64];
    assign w2 = round_key[63:32];
    assign w3 = round_key[31:0];

    // Words are rewritten in place, so word c-1 already holds its new value when word c is updated.
    always_comb begin
        rot_w3 = {w3[23:0], w3[31:24]};
        sub_w3 = {sbox(rot_w3[31:24]), sbox(rot_w3[23:16]),
                  sbox(rot_w3[15:8]),  sbox(rot_w3[7:0])};
        prev_word = 32'h0;
        new_word  = 32'h0;
        next_key  = round_key;
        case (cnt)
            2'd0: begin
                prev_word = sub_w3 ^ {rcon, 24'h000000};
                new_word  = w0 ^ prev_word;
                next_key[127:96] = new_word;
            end
            2'd1: begin
                prev_word = w0;
                new_word  = w1 ^ prev_word;
                next_key[95:64] = new_word;
            end
            2'd2: begin
                prev_word = w1;
                new_word  = w2 ^ prev_word;
                next_key[63:32] = new_word;
            end
            default: begin
                prev_word = w2;
                new_word  = w3 ^ prev_word;
                next_key[31:0] = new_word;
            end
        endcase
    end

    // valid/ready: a round key is offered while key_valid=1 and held until next is accepted;
    // next is only honoured in READY, start is honoured in any state and wins over next.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            round_key <= '0;
            round_num <= 4'd0;
            key_valid <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
            rcon      <= 8'h01;
            cnt       <= 2'd0;
        end else if (start) begin
            state     <= READY;
            round_key <= key_in;
            round_num <= 4'd0;
            key_valid <= 1'b1;
            busy      <= 1'b0;
            done      <= 1'b0;
            rcon      <= 8'h01;
            cnt       <= 2'd0;
        end else begin
            case (state)
                READY: begin
                    if (next && round_num != LAST_ROUND) begin
                        key_valid <= 1'b0;
                        busy      <= 1'b1;
                        cnt       <= 2'd0;
                        state     <= EXPAND;
                    end
                end
                EXPAND: begin
                    round_key <= next_key;
                    cnt       <= cnt + 2'd1;
                    if (cnt == 2'd3) begin
                        round_num <= round_num + 4'd1;
                        rcon      <= xtime(rcon);
                        key_valid <= 1'b1;
                        busy      <= 1'b0;
                        done      <= (round_num + 4'd1 == LAST_ROUND);
                        state     <= READY;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_aes_key_schedule.sv
// Directed bench for aes_key_schedule: FIPS-197 key walk, latency, async reset,
// restart via start and continuously held next.
module tb_aes_key_schedule;

    logic         clk;
    logic         rst;
    logic [127:0] key_in;
    logic         start;
    logic         next;
    logic [127:0] round_key;
    logic [3:0]   round_num;
    logic         key_valid;
    logic         busy;
    logic         done;

    int n_cmp;
    int n_fail;

    localparam logic [127:0] KEY_A = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [127:0] KEY_B = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] KEY_Z = 128'h0;

    typedef struct {
        logic [127:0] key;
        logic [3:0]   num;
        logic         last;
    } vec_t;

    vec_t vecs[10];

    aes_key_schedule #(.word_size(8), .array_size(16), .NR(10)) dut (
        .clk       (clk),
        .rst       (rst),
        .key_in    (key_in),
        .start     (start),
        .next      (next),
        .round_key (round_key),
        .round_num (round_num),
        .key_valid (key_valid),
        .busy      (busy),
        .done      (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_start(input logic [127:0] k, input logic with_next);
        @(negedge clk);
        key_in = k;
        start  = 1'b1;
        next   = with_next;
        step();
        start  = 1'b0;
        next   = 1'b0;
    endtask

    task automatic pulse_next();
        @(negedge clk);
        next = 1'b1;
        step();
        next = 1'b0;
    endtask

    task automatic check_loaded(input string tag, input logic [127:0] k);
        check({tag, "_valid"}, 128'(key_valid), 128'(1'b1));
        check({tag, "_num"},   128'(round_num), 128'(4'd0));
        check({tag, "_key"},   round_key, k);
        check({tag, "_busy"},  128'(busy), 128'(1'b0));
        check({tag, "_done"},  128'(done), 128'(1'b0));
    endtask

    // Called just after the accepting edge; counts cycles with key_valid low.
    task automatic wait_round(input string tag);
        int cyc;
        cyc = 0;
        while (!key_valid && cyc < 20) begin
            check({tag, "_busy_in_expand"}, 128'(busy), 128'(1'b1));
            step();
            cyc++;
        end
        check({tag, "_latency"}, 128'(cyc), 128'(4));
    endtask

    initial begin
        n_cmp  = 0;
        n_fail = 0;
        rst    = 1'b1;
        start  = 1'b0;
        next   = 1'b0;
        key_in = '0;

        vecs[0] = '{128'ha0fafe1788542cb123a339392a6c7605, 4'd1,  1'b0};
        vecs[1] = '{128'hf2c295f27a96b9435935807a7359f67f, 4'd2,  1'b0};
        vecs[2] = '{128'h3d80477d4716fe3e1e237e446d7a883b, 4'd3,  1'b0};
        vecs[3] = '{128'hef44a541a8525b7fb671253bdb0bad00, 4'd4,  1'b0};
        vecs[4] = '{128'hd4d1c6f87c839d87caf2b8bc11f915bc, 4'd5,  1'b0};
        vecs[5] = '{128'h6d88a37a110b3efddbf98641ca0093fd, 4'd6,  1'b0};
        vecs[6] = '{128'h4e54f70e5f5fc9f384a64fb24ea6dc4f, 4'd7,  1'b0};
        vecs[7] = '{128'head27321b58dbad2312bf5607f8d292f, 4'd8,  1'b0};
        vecs[8] = '{128'hac7766f319fadc2128d12941575c006e, 4'd9,  1'b0};
        vecs[9] = '{128'hd014f9a8c9ee2589e13f0cc8b6630ca6, 4'd10, 1'b1};

        repeat (3) step();
        check("reset_key",   round_key, 128'h0);
        check("reset_valid", 128'(key_valid), 128'(1'b0));
        @(negedge clk);
        rst = 1'b0;

        // IDLE ignores next
        pulse_next();
        repeat (5) step();
        check("idle_valid", 128'(key_valid), 128'(1'b0));
        check("idle_busy",  128'(busy), 128'(1'b0));
        check("idle_num",   128'(round_num), 128'(4'd0));
        check("idle_key",   round_key, 128'h0);

        do_start(KEY_A, 1'b0);
        check_loaded("load_a", KEY_A);

        for (int i = 0; i < 10; i++) begin
            pulse_next();
            check($sformatf("r%0d_valid_low", i + 1), 128'(key_valid), 128'(1'b0));
            wait_round($sformatf("r%0d", i + 1));
            check($sformatf("r%0d_key", i + 1),  round_key, vecs[i].key);
            check($sformatf("r%0d_num", i + 1),  128'(round_num), 128'(vecs[i].num));
            check($sformatf("r%0d_done", i + 1), 128'(done), 128'(vecs[i].last));
        end

        // next after the last round key changes nothing
        pulse_next();
        repeat (5) begin
            check("post_last_valid", 128'(key_valid), 128'(1'b1));
            check("post_last_busy",  128'(busy), 128'(1'b0));
            check("post_last_key",   round_key, vecs[9].key);
            check("post_last_num",   128'(round_num), 128'(4'd10));
            check("post_last_done",  128'(done), 128'(1'b1));
            step();
        end

        // start together with next: start wins and clears done
        do_start(KEY_Z, 1'b1);
        check_loaded("start_next", KEY_Z);
        step();
        check("start_next_hold", 128'(key_valid), 128'(1'b1));
        pulse_next();
        wait_round("zero_r1");
        check("zero_r1_key", round_key, 128'h62636363626363636263636362636363);
        check("zero_r1_num", 128'(round_num), 128'(4'd1));

        // start aborts an expansion in progress
        pulse_next();
        step();
        step();
        check("abort_busy_before", 128'(busy), 128'(1'b1));
        do_start(KEY_B, 1'b0);
        check_loaded("abort", KEY_B);
        pulse_next();
        wait_round("b_r1");
        check("b_r1_key", round_key, 128'hd6aa74fdd2af72fadaa678f1d6ab76fe);
        check("b_r1_num", 128'(round_num), 128'(4'd1));

        // next held high: one round per 5 cycles, round 10 after 50
        do_start(KEY_A, 1'b0);
        begin
            int cyc;
            cyc = 0;
            @(negedge clk);
            next = 1'b1;
            while (!(key_valid && round_num == 4'd10) && cyc < 200) begin
                step();
                cyc++;
                if (cyc == 25) begin
                    check("held_r5_num",   128'(round_num), 128'(4'd5));
                    check("held_r5_valid", 128'(key_valid), 128'(1'b1));
                    check("held_r5_key",   round_key, vecs[4].key);
                end
            end
            check("held_cycles", 128'(cyc), 128'(50));
            check("held_r10_key", round_key, vecs[9].key);
            check("held_done", 128'(done), 128'(1'b1));
            next = 1'b0;
        end

        // async reset two cycles into EXPAND
        do_start(KEY_A, 1'b0);
        pulse_next();
        step();
        step();
        #3;
        rst = 1'b1;
        #1;
        check("arst_key",   round_key, 128'h0);
        check("arst_num",   128'(round_num), 128'(4'd0));
        check("arst_valid", 128'(key_valid), 128'(1'b0));
        check("arst_busy",  128'(busy), 128'(1'b0));
        check("arst_done",  128'(done), 128'(1'b0));
        @(negedge clk);
        rst = 1'b0;
        pulse_next();
        repeat (6) begin
            check("arst_idle_valid", 128'(key_valid), 128'(1'b0));
            check("arst_idle_busy",  128'(busy), 128'(1'b0));
            check("arst_idle_key",   round_key, 128'h0);
            step();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/aes_key_schedule.md
Name: aes_key_schedule

Overview:
- Iterative AES-128 key expansion stage, directly upstream of the round-key addition stage.
- Latches the 128-bit cipher key and emits round keys 0..NR one at a time on request.
- Computes one 32-bit word per cycle using a single shared SubWord (4 S-box lookups).
- round_key drives the key input of the round-key addition stage and is held stable while key_valid=1.

Parameters:
- word_size, 8, bits per state byte.
- array_size, 16, bytes per key/state block; key width = word_size*array_size = 128.
- NR, 10, number of rounds; last round key index.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  asynchronous, active-high reset.
- key_in  input  128  cipher key; byte 0 = key_in[127:120] (FIPS-197 order); w0 = key_in[127:96].
- start  input  1  load key_in and restart at round 0; sampled on clk.
- next  input  1  request the next round key; sampled on clk.
- round_key  output  128  current round key, same byte order as key_in.
- round_num  output  4  index of the round key on round_key (0..NR).
- key_valid  output  1  round_key/round_num valid and stable.
- busy  output  1  expansion in progress.
- done  output  1  round key NR reached; level signal.

Behaviour:
- Reset (async, any state): round_key=0, round_num=0, key_valid=0, busy=0, done=0, rcon=8'h01, word counter=0, state=IDLE.
- States: IDLE, READY, EXPAND.
- start has priority over next in every state, including EXPAND (aborts the round in progress).
- On an edge with start=1:
  - round_key<=key_in, round_num<=0, rcon<=8'h01, key_valid<=1, busy<=0, done<=0, state<=READY.
- IDLE: next is ignored; outputs hold reset values.
- READY, next=1, round_num<NR: accept at edge E0.
  - key_valid<=0, busy<=1, counter<=0, state<=EXPAND.
- READY, next=1, round_num==NR: ignored; all outputs hold.
- EXPAND, edges E1..E4 (counter c=0..3), updating round_key in place:
  - c=0: w0' = w0 ^ SubWord(RotWord(w3)) ^ {rcon,8'h00,8'h00,8'h00}.
  - c=1..3: wc' = wc ^ w(c-1)', where w(c-1)' is the word updated on the previous edge.
  - At E4: round_num<=round_num+1, rcon<=xtime(rcon), key_valid<=1, busy<=0, state<=READY.
  - At E4, if the new round_num==NR, done<=1.
- Latency: next accepted at E0; key_valid low for exactly 4 cycles; next round key valid after E4.
- next during EXPAND is ignored; it is neither queued nor counted.
- RotWord: {b0,b1,b2,b3} -> {b1,b2,b3,b0}.
- SubWord: applies the FIPS-197 S-box to each byte; full 256-entry combinational table inside this block.
- xtime: (rcon<<1) ^ (rcon[7] ? 8'h1B : 8'h00), truncated to 8 bits.
  - Rcon sequence: 01,02,04,08,10,20,40,80,1B,36.
- round_key does not change while key_valid=1.
- Intermediate round_key values during EXPAND are not meaningful to consumers.
- done stays 1 until the next start or reset.

Test Plan:
- start with key_in=2b7e151628aed2a6abf7158809cf4f3c -> one cycle later: key_valid=1, round_num=0, round_key equals key_in, done=0.
- After load, pulse next -> key_valid=0 and busy=1 for 4 cycles, then round_num=1, round_key=a0fafe1788542cb123a339392a6c7605; second next -> f2c295f27a96b9435935807a7359f67f.
- Issue next repeatedly to the end:
  - round 9 = ac7766f319fadc2128d12941575c006e (checks rcon 1B).
  - round 10 = d014f9a8c9ee2589e13f0cc8b6630ca6, done=1.
  - A further next leaves all outputs unchanged.
- Assert rst asynchronously two cycles into EXPAND -> all outputs zero immediately, without waiting for a clock edge, state IDLE. next while in IDLE -> no response.
- start with a new key during EXPAND, and start asserted together with next -> restart: round_num=0, round_key=new key, busy=0, done=0; subsequent round 1 is correct for the new key.
- Hold next high continuously from round 0 -> exactly one round advance per 5 cycles (accept + 4 expand), reaching round 10 after 50 cycles; next samples taken during EXPAND are ignored.
